prio_encoder_reg: RTL and testbench

PRIO_ENCODER_REG -- requirements
Module: prio_encoder_reg

---
 rtl/prio_encoder_reg.sv | 101 ++++++++++
 tb/tb_prio_encoder_reg.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/prio_encoder_reg.sv
// Registered priority encoder with a valid/ready output handshake.
// Define PRIO_ENC_RR_EN for round-robin arbitration; default is fixed highest-index priority.
module prio_encoder_reg #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] i,
    input  logic         out_ready,
    output logic         in_ready,
    output logic [W-1:0] y,
    output logic         valid,
    output logic         multi
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]   r_state;
    logic [W-1:0] r_y;
    logic         r_multi;

    logic [W-1:0] w_sel;
    logic         w_any;
    logic         w_multi;
    logic         w_capture;

    assign w_any     = |i;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign w_multi   = |(i & (i - N'(1)));
    assign in_ready  = (r_state == ST_EMPTY) || out_ready;
    assign w_capture = en && in_ready && w_any;

`ifdef PRIO_ENC_RR_EN
    logic [W-1:0] r_ptr;
    logic [W-1:0] w_sel_hi;
    logic [W-1:0] w_sel_lo;
    logic         w_found_hi;

    // NOTE: every comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_sel_hi   = '0;
        w_sel_lo   = '0;
        w_found_hi = 1'b0;
        // Scanning downward, the last hit is the lowest index in each class.
        for (int k = N - 1; k >= 0; k--) begin
            if (i[k]) begin
                w_sel_lo = W'(k);
                if (W'(k) >= r_ptr) begin
                    w_sel_hi   = W'(k);
                    w_found_hi = 1'b1;
                end
            end
        end
        w_sel = w_found_hi ? w_sel_hi : w_sel_lo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_capture) begin
            r_ptr <= (w_sel == W'(N - 1)) ? '0 : w_sel + W'(1);
        end
    end
`else
    always_comb begin
        w_sel = '0;
        for (int k = 0; k < N; k++) begin
            if (i[k]) begin
                w_sel = W'(k);
            end
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_y     <= '0;
            r_multi <= 1'b0;
        end else begin
            if (w_capture) begin
                r_y     <= w_sel;
                r_multi <= w_multi;
            end
            case (r_state)
                ST_EMPTY: if (w_capture) r_state <= ST_FULL;
                ST_FULL:  if (!w_capture && out_ready) r_state <= ST_EMPTY;
                default:  r_state <= ST_EMPTY;
            endcase
        end
    end

    assign y     = r_y;
    assign valid = (r_state == ST_FULL);
    assign multi = r_multi;

endmodule

// File: tb/tb_prio_encoder_reg.sv
// Self-checking bench for prio_encoder_reg: directed scenarios plus random traffic
// compared against a behavioural model (follows PRIO_ENC_RR_EN when defined).
module tb_prio_encoder_reg;

    localparam int N = 8;
    localparam int W = $clog2(N);

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [N-1:0] i;
    logic         out_ready;
    logic         in_ready;
    logic [W-1:0] y;
    logic         valid;
    logic         multi;

    int n_vec  = 0;
    int n_fail = 0;

    bit m_valid = 1'b0;
    int m_y     = 0;
    bit m_multi = 1'b0;
    int m_ptr   = 0;

    prio_encoder_reg #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .i         (i),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .y         (y),
        .valid     (valid),
        .multi     (multi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference selection written from the arbitration rules, not the RTL structure.
    function automatic int ref_sel(input logic [N-1:0] v, input int p);
`ifdef PRIO_ENC_RR_EN
        for (int d = 0; d < N; d++) begin
            if (v[(p + d) % N]) return (p + d) % N;
        end
        return 0;
`else
        return $clog2(int'(v) + 1) - 1;
`endif
    endfunction

    task automatic step(input logic t_rst, input logic t_en, input logic [N-1:0] t_i,
                        input logic t_or);
        bit cap;
        int s;
        @(negedge clk);
        rst       = t_rst;
        en        = t_en;
        i         = t_i;
        out_ready = t_or;
        #1;
        check("in_ready", {31'b0, in_ready}, {31'b0, (!m_valid || t_or)});
        cap = !t_rst && t_en && (!m_valid || t_or) && (t_i != '0);
        @(posedge clk);
        if (t_rst) begin
            m_valid = 1'b0;
            m_y     = 0;
            m_multi = 1'b0;
            m_ptr   = 0;
        end else if (cap) begin
            s       = ref_sel(t_i, m_ptr);
            m_y     = s;
            m_multi = ($countones(t_i) > 1);
            m_valid = 1'b1;
            m_ptr   = (s + 1) % N;
        end else if (m_valid && t_or) begin
            m_valid = 1'b0;
        end
        #1;
        check("y",     {{(32-W){1'b0}}, y}, m_y);
        check("valid", {31'b0, valid},      {31'b0, m_valid});
        check("multi", {31'b0, multi},      {31'b0, m_multi});
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        i         = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state
        step(1'b1, 1'b1, 8'hFF, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check("rst_y", {{(32-W){1'b0}}, y}, 0);
        check("rst_valid", {31'b0, valid}, 0);

        // One-hot walk with en alternating
        for (int k = 0; k < N; k++) begin
            step(1'b0, 1'b0, N'(1) << k, 1'b1);
            check("walk_idle_valid", {31'b0, valid}, 0);
            step(1'b0, 1'b1, N'(1) << k, 1'b1);
            check("walk_y", {{(32-W){1'b0}}, y}, k);
            check("walk_multi", {31'b0, multi}, 0);
        end

`ifndef PRIO_ENC_RR_EN
        // Fixed priority with multiple requests
        step(1'b0, 1'b1, 8'b1010_0110, 1'b1);
        check("fp_y7", {{(32-W){1'b0}}, y}, 7);
        check("fp_multi7", {31'b0, multi}, 1);
        step(1'b0, 1'b1, 8'b0000_0110, 1'b1);
        check("fp_y2", {{(32-W){1'b0}}, y}, 2);

        // Backpressure hold, then back-to-back replace
        step(1'b0, 1'b1, 8'h04, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b1, 8'h80, 1'b0);
            check("hold_y", {{(32-W){1'b0}}, y}, 2);
            check("hold_in_ready", {31'b0, in_ready}, 0);
        end
        step(1'b0, 1'b1, 8'h80, 1'b1);
        check("b2b_y", {{(32-W){1'b0}}, y}, 7);
        check("b2b_valid", {31'b0, valid}, 1);

        // Empty request consumes without capture
        step(1'b0, 1'b1, 8'h00, 1'b1);
        check("zero_valid", {31'b0, valid}, 0);
        check("zero_y_held", {{(32-W){1'b0}}, y}, 7);
`else
        // Round-robin rotation over a full request vector
        step(1'b1, 1'b0, 8'h00, 1'b1);
        for (int k = 0; k <= N; k++) begin
            step(1'b0, 1'b1, 8'hFF, 1'b1);
            check("rr_seq", {{(32-W){1'b0}}, y}, k % N);
        end
        step(1'b0, 1'b1, 8'h21, 1'b1);
        check("rr_y5", {{(32-W){1'b0}}, y}, 5);
        step(1'b0, 1'b1, 8'h21, 1'b1);
        check("rr_wrap0", {{(32-W){1'b0}}, y}, 0);
`endif

        // Mid-stream reset discards a held result
        step(1'b0, 1'b1, 8'h48, 1'b0);
        step(1'b1, 1'b1, 8'h48, 1'b0);
        check("midrst_valid", {31'b0, valid}, 0);
        check("midrst_y", {{(32-W){1'b0}}, y}, 0);
        check("midrst_multi", {31'b0, multi}, 0);
        step(1'b0, 1'b1, 8'hFF, 1'b1);
`ifdef PRIO_ENC_RR_EN
        check("midrst_ptr0", {{(32-W){1'b0}}, y}, 0);
`else
        check("midrst_first", {{(32-W){1'b0}}, y}, 7);
`endif

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            logic         r_rst;
            logic         r_en;
            logic [N-1:0] r_i;
            logic         r_or;
            r_rst = ($urandom_range(0, 39) == 0);
            r_en  = ($urandom_range(0, 3) != 0);
            r_i   = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
            r_or  = ($urandom_range(0, 2) != 0);
            step(r_rst, r_en, r_i, r_or);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
